// File: rtl/layer_scheduler_if.sv
// Config-FIFO and tile-command bundle shared by the layer scheduler (master)
// and the config FIFO / PE datapath side (slave).
interface layer_scheduler_if #(
  parameter int FRAME_WIDTH  = 6,
  parameter int PATCH_WIDTH  = 6,
  parameter int FTRGRP_WIDTH = 4,
  parameter int LAYER_WIDTH  = 4
);
  logic                    CFGIF_rdy;
  logic [5:0]              CFG_LoopPty;
  logic [FRAME_WIDTH-1:0]  CFG_NumFrm;
  logic [PATCH_WIDTH-1:0]  CFG_NumPat;
  logic [FTRGRP_WIDTH-1:0] CFG_NumFtrGrp;
  logic [LAYER_WIDTH-1:0]  CFG_NumLay;
  logic                    Rst_Layer;
  logic                    tile_val;
  logic                    tile_rdy;
  logic                    tile_done;
  logic [FRAME_WIDTH-1:0]  cur_frm;
  logic [PATCH_WIDTH-1:0]  cur_pat;
  logic [FTRGRP_WIDTH-1:0] cur_ftrgrp;
  logic [LAYER_WIDTH-1:0]  cur_lay;

  modport master (
    input  CFGIF_rdy, CFG_LoopPty, CFG_NumFrm, CFG_NumPat, CFG_NumFtrGrp, CFG_NumLay,
    input  tile_rdy, tile_done,
    output Rst_Layer, tile_val, cur_frm, cur_pat, cur_ftrgrp, cur_lay
  );

  modport slave (
    output CFGIF_rdy, CFG_LoopPty, CFG_NumFrm, CFG_NumPat, CFG_NumFtrGrp, CFG_NumLay,
    output tile_rdy, tile_done,
    input  Rst_Layer, tile_val, cur_frm, cur_pat, cur_ftrgrp, cur_lay
  );
endinterface

// File: rtl/layer_scheduler.sv
// Layer-by-layer sequencer: latches one config word per layer, walks the
// frame/patch/filter-group loop nest one tile at a time, then pops the FIFO.
module layer_scheduler #(
  parameter int FRAME_WIDTH  = 6,
  parameter int PATCH_WIDTH  = 6,
  parameter int FTRGRP_WIDTH = 4,
  parameter int LAYER_WIDTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              net_done,
  layer_scheduler_if.master bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_CFG  = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_NEXT      = 3'd4;
  localparam logic [2:0] S_LAYER_END = 3'd5;
  localparam logic [2:0] S_GAP       = 3'd6;

  logic [2:0]              state;
  logic [FRAME_WIDTH-1:0]  num_frm, frm_idx, frm_nxt;
  logic [PATCH_WIDTH-1:0]  num_pat, pat_idx, pat_nxt;
  logic [FTRGRP_WIDTH-1:0] num_grp, grp_idx, grp_nxt;
  logic [LAYER_WIDTH-1:0]  num_lay, lay_idx;
  logic                    loop_pty;
  logic                    frm_last, pat_last, grp_last, all_last;
  logic                    unused_pty;

  // Only the patch/ftrgrp ordering bit of the loop-priority field is meaningful.
  assign unused_pty = ^bus.CFG_LoopPty[5:1];

  assign busy           = (state != S_IDLE);
  assign net_done       = (state == S_GAP) && (lay_idx == num_lay);
  assign bus.Rst_Layer  = (state == S_LAYER_END);
  assign bus.tile_val   = (state == S_ISSUE);
  assign bus.cur_frm    = frm_idx;
  assign bus.cur_pat    = pat_idx;
  assign bus.cur_ftrgrp = grp_idx;
  assign bus.cur_lay    = lay_idx;

  // Odometer step: the inner loop always moves, the middle one carries off
  // the inner, and the frame carries only when both lower loops wrap.
  always_comb begin
    frm_last = (frm_idx == num_frm);
    pat_last = (pat_idx == num_pat);
    grp_last = (grp_idx == num_grp);
    all_last = frm_last && pat_last && grp_last;
    frm_nxt  = frm_idx;
    pat_nxt  = pat_idx;
    grp_nxt  = grp_idx;
    if (!loop_pty) begin
      grp_nxt = grp_last ? '0 : grp_idx + 1'b1;
      if (grp_last)
        pat_nxt = pat_last ? '0 : pat_idx + 1'b1;
    end else begin
      pat_nxt = pat_last ? '0 : pat_idx + 1'b1;
      if (pat_last)
        grp_nxt = grp_last ? '0 : grp_idx + 1'b1;
    end
    if (grp_last && pat_last)
      frm_nxt = frm_last ? '0 : frm_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      num_frm  <= '0;
      num_pat  <= '0;
      num_grp  <= '0;
      num_lay  <= '0;
      loop_pty <= 1'b0;
      frm_idx  <= '0;
      pat_idx  <= '0;
      grp_idx  <= '0;
      lay_idx  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            lay_idx <= '0;
            state   <= S_WAIT_CFG;
          end
        end
        S_WAIT_CFG: begin
          if (bus.CFGIF_rdy) begin
            num_frm  <= bus.CFG_NumFrm;
            num_pat  <= bus.CFG_NumPat;
            num_grp  <= bus.CFG_NumFtrGrp;
            loop_pty <= bus.CFG_LoopPty[0];
            // The network depth comes only from the first layer's word.
            if (lay_idx == '0)
              num_lay <= bus.CFG_NumLay;
            frm_idx  <= '0;
            pat_idx  <= '0;
            grp_idx  <= '0;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.tile_rdy)
            state <= S_RUN;
        end
        S_RUN: begin
          if (bus.tile_done)
            state <= S_NEXT;
        end
        S_NEXT: begin
          frm_idx <= frm_nxt;
          pat_idx <= pat_nxt;
          grp_idx <= grp_nxt;
          state   <= all_last ? S_LAYER_END : S_ISSUE;
        end
        S_LAYER_END: state <= S_GAP;
        S_GAP: begin
          if (lay_idx == num_lay) begin
            state <= S_IDLE;
          end else begin
            lay_idx <= lay_idx + 1'b1;
            state   <= S_WAIT_CFG;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_scheduler.sv
// Scoreboard bench for layer_scheduler: a loop-nest model predicts the event
// stream (tiles, layer ends, net done) and a monitor consumes it.
module tb_layer_scheduler;
  localparam int FW     = 6;
  localparam int PW     = 6;
  localparam int GW     = 4;
  localparam int LW     = 4;
  localparam int PERIOD = 10;
  localparam int LIMIT  = 20000;

  localparam int EV_TILE = 0;
  localparam int EV_LEND = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int frm;
    int pat;
    int grp;
    int pty;
    int lay;
  } cfg_t;

  typedef struct {
    int kind;
    int lay;
    int frm;
    int pat;
    int grp;
    bit first;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic net_done;

  cfg_t fifo[$];
  ev_t  exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   rst_count = 0;
  int   ndone_cnt = 0;
  time  done_time = 0;
  bit   rdy_random = 1'b0;
  int   done_delay = 1;
  bit   spur_en = 1'b0;
  int   hold_req = 0;

  layer_scheduler_if #(.FRAME_WIDTH(FW), .PATCH_WIDTH(PW), .FTRGRP_WIDTH(GW), .LAYER_WIDTH(LW)) bus ();

  layer_scheduler #(.FRAME_WIDTH(FW), .PATCH_WIDTH(PW), .FTRGRP_WIDTH(GW), .LAYER_WIDTH(LW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .net_done (net_done),
    .bus      (bus)
  );

  always #(PERIOD/2) clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic cfg_t make_cfg(input int f, input int p, input int g, input int pty, input int l);
    cfg_t c;
    c.frm = f; c.pat = p; c.grp = g; c.pty = pty; c.lay = l;
    return c;
  endfunction

  function automatic void push_ev(input int kind, input int l, input int f, input int p, input int g, input bit first);
    ev_t e;
    e.kind = kind; e.lay = l; e.frm = f; e.pat = p; e.grp = g; e.first = first;
    exp_q.push_back(e);
  endfunction

  function automatic logic [31:0] pack_tile(input int l, input int f, input int p, input int g);
    return 32'((l << 16) | (f << 10) | (p << 4) | g);
  endfunction

  // Reference model: plain nested loops in the order the loop priority names.
  function automatic void build_expected(input cfg_t cfgs[$]);
    int nl = cfgs[0].lay;
    for (int l = 0; l <= nl; l++) begin
      cfg_t c = cfgs[l];
      bit first = 1'b1;
      int n_out = (c.pty != 0) ? c.grp : c.pat;
      int n_in  = (c.pty != 0) ? c.pat : c.grp;
      for (int f = 0; f <= c.frm; f++)
        for (int o = 0; o <= n_out; o++)
          for (int i = 0; i <= n_in; i++) begin
            if (c.pty != 0) push_ev(EV_TILE, l, f, i, o, first);
            else            push_ev(EV_TILE, l, f, o, i, first);
            first = 1'b0;
          end
      push_ev(EV_LEND, l, 0, 0, 0, 1'b0);
    end
    push_ev(EV_DONE, nl, 0, 0, 0, 1'b0);
  endfunction

  task automatic pop_expect(input int kind, input string name, output ev_t e, output bit ok);
    ok = 1'b0;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: got an event, expected none pending", name);
    end else begin
      e = exp_q.pop_front();
      checkOutput({name, "_kind"}, kind, e.kind);
      ok = (e.kind == kind);
    end
  endtask

  // Config FIFO model: head word drives CFG_*, Rst_Layer pops it.
  initial begin : cfg_fifo
    bus.CFGIF_rdy = 1'b0;
    bus.CFG_LoopPty = '0;
    bus.CFG_NumFrm = '0;
    bus.CFG_NumPat = '0;
    bus.CFG_NumFtrGrp = '0;
    bus.CFG_NumLay = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.Rst_Layer) begin
        if (fifo.size() > 0) void'(fifo.pop_front());
        rst_count++;
      end
      if (fifo.size() > 0) begin
        bus.CFGIF_rdy     = 1'b1;
        bus.CFG_LoopPty   = {5'($urandom), 1'(fifo[0].pty)};
        bus.CFG_NumFrm    = FW'(fifo[0].frm);
        bus.CFG_NumPat    = PW'(fifo[0].pat);
        bus.CFG_NumFtrGrp = GW'(fifo[0].grp);
        bus.CFG_NumLay    = LW'(fifo[0].lay);
      end else begin
        bus.CFGIF_rdy     = 1'b0;
        bus.CFG_LoopPty   = 6'($urandom);
        bus.CFG_NumFrm    = FW'($urandom);
        bus.CFG_NumPat    = PW'($urandom);
        bus.CFG_NumFtrGrp = GW'($urandom);
        bus.CFG_NumLay    = LW'($urandom);
      end
    end
  end

  // Datapath model: accepts tiles, finishes them after a delay, and can stall
  // acceptance or inject tile_done pulses while a tile is still waiting.
  initial begin : datapath
    int done_cnt = 0;
    int hold_left = 0;
    bit pend = 1'b0;
    bit in_hold;
    bus.tile_rdy = 1'b0;
    bus.tile_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.tile_done = 1'b0;
      if (!rst_n) begin
        done_cnt = 0; hold_left = 0; pend = 1'b0; bus.tile_rdy = 1'b0;
        continue;
      end
      if (pend) begin
        done_cnt = (done_delay > 0) ? done_delay : int'($urandom_range(1, 4));
        pend = 1'b0;
      end
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          bus.tile_done = 1'b1;
          done_time = $time;
        end
      end
      if (bus.tile_val && hold_req > 0) begin
        hold_left = hold_req;
        hold_req = 0;
      end
      in_hold = (hold_left > 0);
      if (in_hold) begin
        bus.tile_rdy = 1'b0;
        hold_left--;
      end else begin
        bus.tile_rdy = rdy_random ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      if (bus.tile_val && done_cnt == 0 && (in_hold || (spur_en && $urandom_range(0, 1) == 1)))
        bus.tile_done = 1'b1;
      pend = bus.tile_val && bus.tile_rdy;
    end
  end

  // Monitor: every new tile, layer end and net_done pops the scoreboard.
  initial begin : monitor
    bit   showing = 1'b0;
    bit   ok;
    ev_t  e;
    logic [31:0] held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        showing = 1'b0;
        continue;
      end
      if (bus.tile_val) begin
        if (!showing) begin
          showing = 1'b1;
          pop_expect(EV_TILE, "tile", e, ok);
          if (ok) begin
            held = pack_tile(e.lay, e.frm, e.pat, e.grp);
            checkOutput("tile_index", 32'({bus.cur_lay, bus.cur_frm, bus.cur_pat, bus.cur_ftrgrp}), held);
            if (!e.first)
              checkOutput("tile_gap_cycles", 32'(($time - done_time) / PERIOD), 2);
          end
        end else begin
          checkOutput("tile_hold", 32'({bus.cur_lay, bus.cur_frm, bus.cur_pat, bus.cur_ftrgrp}), held);
        end
      end else begin
        showing = 1'b0;
      end
      if (bus.Rst_Layer) begin
        pop_expect(EV_LEND, "rst_layer", e, ok);
        if (ok) checkOutput("rst_layer_lay", 32'(bus.cur_lay), e.lay);
      end
      if (net_done) begin
        pop_expect(EV_DONE, "net_done", e, ok);
        if (ok) checkOutput("net_done_lay", 32'(bus.cur_lay), e.lay);
        ndone_cnt++;
      end
    end
  end

  // push_mode: 0 = push all configs, 1 = push later layers only after the
  // first pop, 2 = configs already sitting in the FIFO.
  task automatic applyStimulus(input cfg_t cfgs[$], input int push_mode, input bit poke_start);
    int base_rst  = rst_count;
    int base_done = ndone_cnt;
    int nl = cfgs[0].lay;
    int cyc;
    build_expected(cfgs);
    if (push_mode == 0) foreach (cfgs[i]) fifo.push_back(cfgs[i]);
    if (push_mode == 1) fifo.push_back(cfgs[0]);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!bus.tile_val && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("start_latency", cyc, 2);
    if (push_mode == 1) begin
      cyc = 0;
      while (rst_count == base_rst && cyc < LIMIT) begin
        @(negedge clk);
        cyc++;
      end
      repeat (10) begin
        @(negedge clk);
        checkOutput("stall_busy", busy, 1);
        checkOutput("stall_tile_val", bus.tile_val, 0);
      end
      for (int i = 1; i < cfgs.size(); i++) fifo.push_back(cfgs[i]);
    end
    if (poke_start) begin
      cyc = 0;
      while (!bus.tile_val && cyc < LIMIT) begin @(negedge clk); cyc++; end
      while (bus.tile_val && cyc < LIMIT) begin @(negedge clk); cyc++; end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    cyc = 0;
    while (ndone_cnt == base_done && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("run_completed", ndone_cnt - base_done, 1);
    @(negedge clk);
    checkOutput("idle_busy", busy, 0);
    checkOutput("rst_layer_count", rst_count - base_rst, nl + 1);
    checkOutput("scoreboard_empty", exp_q.size(), 0);
    checkOutput("fifo_drained", fifo.size(), 0);
    exp_q.delete();
    fifo.delete();
  endtask

  initial begin : watchdog
    #(PERIOD * 95000);
    $display("[TB] FAIL watchdog: got no completion, expected run to finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    cfg_t cl[$];
    cfg_t rest[$];
    int   base_rst;
    int   cyc;
    int   nl;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_net_done", net_done, 0);
    checkOutput("reset_rst_layer", bus.Rst_Layer, 0);
    checkOutput("reset_tile_val", bus.tile_val, 0);
    checkOutput("reset_cur", 32'({bus.cur_lay, bus.cur_frm, bus.cur_pat, bus.cur_ftrgrp}), 0);
    rst_n = 1'b1;

    // Single layer, single tile.
    rdy_random = 1'b0; done_delay = 3; spur_en = 1'b0;
    cl.delete(); cl.push_back(make_cfg(0, 0, 0, 0, 0));
    applyStimulus(cl, 0, 1'b0);

    // 12 tiles in both loop orders.
    done_delay = 2;
    cl.delete(); cl.push_back(make_cfg(1, 2, 1, 0, 0));
    applyStimulus(cl, 0, 1'b0);
    cl.delete(); cl.push_back(make_cfg(1, 2, 1, 1, 0));
    applyStimulus(cl, 0, 1'b0);

    // Three layers with the later configs arriving late.
    cl.delete();
    cl.push_back(make_cfg(0, 1, 1, 0, 2));
    cl.push_back(make_cfg(1, 0, 1, 1, 7));
    cl.push_back(make_cfg(0, 2, 0, 1, 0));
    applyStimulus(cl, 1, 1'b0);

    // Stalled acceptance, stray tile_done and stray start.
    done_delay = 3; hold_req = 5;
    cl.delete(); cl.push_back(make_cfg(0, 1, 1, 0, 0));
    applyStimulus(cl, 0, 1'b1);

    // Full-range counters: 64 patches x 16 groups, then 64 frames.
    done_delay = 1;
    cl.delete();
    cl.push_back(make_cfg(0, 63, 15, int'($urandom_range(0, 1)), 1));
    cl.push_back(make_cfg(63, 0, 0, 0, 5));
    applyStimulus(cl, 0, 1'b0);

    // Randomized networks with random handshake timing.
    rdy_random = 1'b1; done_delay = 0; spur_en = 1'b1;
    for (int r = 0; r < 4; r++) begin
      cl.delete();
      nl = int'($urandom_range(0, 2));
      for (int l = 0; l <= nl; l++)
        cl.push_back(make_cfg(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                              int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                              (l == 0) ? nl : int'($urandom_range(0, 3))));
      applyStimulus(cl, 0, 1'b0);
    end

    // Reset in the middle of layer 1, then rerun from the FIFO head.
    rdy_random = 1'b0; done_delay = 4; spur_en = 1'b0;
    cl.delete();
    cl.push_back(make_cfg(1, 1, 1, 0, 1));
    cl.push_back(make_cfg(0, 1, 2, 1, 0));
    build_expected(cl);
    foreach (cl[i]) fifo.push_back(cl[i]);
    base_rst = rst_count;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (rst_count == base_rst && cyc < LIMIT) begin @(negedge clk); cyc++; end
    while (!bus.tile_val && cyc < LIMIT) begin @(negedge clk); cyc++; end
    while (bus.tile_val && cyc < LIMIT) begin @(negedge clk); cyc++; end
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrun_reset_busy", busy, 0);
    checkOutput("midrun_reset_net_done", net_done, 0);
    checkOutput("midrun_reset_rst_layer", bus.Rst_Layer, 0);
    checkOutput("midrun_reset_tile_val", bus.tile_val, 0);
    checkOutput("midrun_reset_cur", 32'({bus.cur_lay, bus.cur_frm, bus.cur_pat, bus.cur_ftrgrp}), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midrun_reset_pops", rst_count - base_rst, 1);
    rest = fifo;
    applyStimulus(rest, 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
